tc0480scp_rom_arbiter: RTL and testbench

- Shares the single toggle-handshake graphics ROM port of the TC0480SCP among NUM_REQ tile-fetch requesters: BG0-BG3 and, later, further layer or zoom fetchers.
- Each requester issues a toggle request with an address and a null-tile flag.
- The arbiter grants requesters round-robin, drives the ROM handshake and returns the ROM word with a one-cycle per-requester load strobe.
- It sits between the per-layer attribute fetch logic and the SDRAM ROM channel.

---
 rtl/tc0480scp_rom_arbiter_if.sv | 30 +++
 rtl/tc0480scp_rom_arbiter.sv | 156 +++++++++++++++
 tb/tb_tc0480scp_rom_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tc0480scp_rom_arbiter_if.sv
// Requester and ROM-side signals of the TC0480SCP tile-fetch ROM arbiter.
// The slave view belongs to the arbiter; the master view to requesters plus ROM.
interface tc0480scp_rom_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 23,
   parameter int DATA_W  = 64
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        req_null;
   logic [NUM_REQ-1:0]        ack;
   logic [NUM_REQ-1:0]        load;
   logic [DATA_W-1:0]         data_out;
   logic                      flush;
   logic                      busy;
   logic [ADDR_W-1:0]         rom_address;
   logic                      rom_req;
   logic                      rom_ack;
   logic [DATA_W-1:0]         rom_data;

   modport slave (
      input  req, req_addr, req_null, flush, rom_ack, rom_data,
      output ack, load, data_out, busy, rom_address, rom_req
   );

   modport master (
      output req, req_addr, req_null, flush, rom_ack, rom_data,
      input  ack, load, data_out, busy, rom_address, rom_req
   );
endinterface

// File: rtl/tc0480scp_rom_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake graphics ROM port among
// NUM_REQ tile fetchers; returns each ROM word with a one-cycle load strobe.
module tc0480scp_rom_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 23,
   parameter int DATA_W  = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   tc0480scp_rom_arbiter_if.slave        bus
);
   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic {
      IDLE,
      BUSY
   } state_e;

   state_e             r_state;
   state_e             w_stateNext;
   logic [IDX_W-1:0]   r_lastGrant;
   logic [IDX_W-1:0]   w_lastGrantNext;
   logic [IDX_W-1:0]   r_grant;
   logic [IDX_W-1:0]   w_grantNext;
   logic               r_snap;
   logic               w_snapNext;
   logic [NUM_REQ-1:0] r_ack;
   logic [NUM_REQ-1:0] w_ackNext;
   logic [NUM_REQ-1:0] r_load;
   logic [NUM_REQ-1:0] w_loadNext;
   logic [DATA_W-1:0]  r_dataOut;
   logic [DATA_W-1:0]  w_dataOutNext;
   logic [ADDR_W-1:0]  r_romAddr;
   logic [ADDR_W-1:0]  w_romAddrNext;
   logic               r_romReq;
   logic               w_romReqNext;
   logic               r_busy;
   logic               w_busyNext;
   logic               r_discard;
   logic               w_discardNext;

   logic [NUM_REQ-1:0] w_pending;
   logic [IDX_W-1:0]   w_sel;
   logic               w_found;
   logic               w_romDone;

   assign w_pending = bus.req ^ r_ack;
   assign w_romDone = (bus.rom_ack == r_romReq);

   // Search starts just after the last winner so every requester gets a turn.
   always_comb begin : pickGrant
      int idx;
      idx     = 0;
      w_found = 1'b0;
      w_sel   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(r_lastGrant) + k) % NUM_REQ;
         if (!w_found && w_pending[idx]) begin
            w_found = 1'b1;
            w_sel   = IDX_W'(idx);
         end
      end
   end

   always_comb begin : nextState
      w_stateNext     = r_state;
      w_lastGrantNext = r_lastGrant;
      w_grantNext     = r_grant;
      w_snapNext      = r_snap;
      w_ackNext       = r_ack;
      w_loadNext      = '0;
      w_dataOutNext   = r_dataOut;
      w_romAddrNext   = r_romAddr;
      w_romReqNext    = r_romReq;
      w_busyNext      = r_busy;
      w_discardNext   = r_discard;

      case (r_state)
         IDLE: begin
            if (bus.flush) begin
               w_ackNext = bus.req;
            end else if (w_found) begin
               w_lastGrantNext = w_sel;
               w_grantNext     = w_sel;
               w_snapNext      = bus.req[w_sel];
               if (bus.req_null[w_sel]) begin
                  w_dataOutNext      = '0;
                  w_loadNext[w_sel]  = 1'b1;
                  w_ackNext[w_sel]   = bus.req[w_sel];
               end else begin
                  w_romAddrNext = bus.req_addr[int'(w_sel)*ADDR_W +: ADDR_W];
                  w_romReqNext  = ~r_romReq;
                  w_busyNext    = 1'b1;
                  w_stateNext   = BUSY;
               end
            end
         end

         BUSY: begin
            if (bus.flush) begin
               w_ackNext     = bus.req;
               w_discardNext = 1'b1;
            end
            // The ROM toggle cannot be withdrawn, so a flushed access still waits for its return.
            if (w_romDone) begin
               w_busyNext    = 1'b0;
               w_discardNext = 1'b0;
               w_stateNext   = IDLE;
               if (!bus.flush && !r_discard) begin
                  w_dataOutNext        = bus.rom_data;
                  w_loadNext[r_grant]  = 1'b1;
                  w_ackNext[r_grant]   = r_snap;
               end
            end
         end

         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_lastGrant <= IDX_W'(NUM_REQ - 1);
         r_grant     <= '0;
         r_snap      <= 1'b0;
         r_ack       <= '0;
         r_load      <= '0;
         r_dataOut   <= '0;
         r_romAddr   <= '0;
         r_romReq    <= 1'b0;
         r_busy      <= 1'b0;
         r_discard   <= 1'b0;
      end else begin
         r_state     <= w_stateNext;
         r_lastGrant <= w_lastGrantNext;
         r_grant     <= w_grantNext;
         r_snap      <= w_snapNext;
         r_ack       <= w_ackNext;
         r_load      <= w_loadNext;
         r_dataOut   <= w_dataOutNext;
         r_romAddr   <= w_romAddrNext;
         r_romReq    <= w_romReqNext;
         r_busy      <= w_busyNext;
         r_discard   <= w_discardNext;
      end
   end

   assign bus.ack         = r_ack;
   assign bus.load        = r_load;
   assign bus.data_out    = r_dataOut;
   assign bus.rom_address = r_romAddr;
   assign bus.rom_req     = r_romReq;
   assign bus.busy        = r_busy;

endmodule

// File: tb/tb_tc0480scp_rom_arbiter.sv
// Scoreboard bench for tc0480scp_rom_arbiter: stimulus queues expected ROM
// addresses and load returns, a monitor pops and compares them.
module tb_tc0480scp_rom_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 23;
   localparam int DATA_W  = 64;
   localparam int ROM_LAT = 5;

   logic clk;
   logic reset;

   int checks = 0;
   int passes = 0;
   int cycle  = 0;

   logic [ADDR_W-1:0] expAddrQ[$];
   int                expLoadIdx[$];
   logic [DATA_W-1:0] expLoadData[$];
   int                toggleCycles[$];

   logic              prevRomReq = 1'b0;
   int                romCnt;
   logic [ADDR_W-1:0] monAddr;
   int                monIdx;
   logic [DATA_W-1:0] monData;
   logic [DATA_W-1:0] dataBefore;

   tc0480scp_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   tc0480scp_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   function automatic logic [63:0] romWord(input logic [22:0] a);
      if (a == 23'h012340) return 64'hDEADBEEF_01234567;
      return {8'hA5, 1'b0, a, 9'h0, a};
   endfunction

   // ROM model: answers a toggled request ROM_LAT cycles later.
   always @(posedge clk) begin
      if (reset) begin
         bus.rom_ack  <= 1'b0;
         bus.rom_data <= '0;
         romCnt       <= 0;
      end else if (bus.rom_req != bus.rom_ack) begin
         if (romCnt == ROM_LAT - 1) begin
            bus.rom_ack  <= bus.rom_req;
            bus.rom_data <= romWord(bus.rom_address);
            romCnt       <= 0;
         end else begin
            romCnt <= romCnt + 1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Monitor: every ROM toggle and every load is matched against the scoreboard.
   always @(posedge clk) begin
      #1;
      if (reset) begin
         prevRomReq = bus.rom_req;
      end else begin
         if (bus.rom_req !== prevRomReq) begin
            prevRomReq = bus.rom_req;
            toggleCycles.push_back(cycle);
            monAddr = (expAddrQ.size() != 0) ? expAddrQ.pop_front() : '1;
            checkOutput("rom_address at toggle", 64'(bus.rom_address), 64'(monAddr));
         end
         if (bus.load != '0) begin
            monIdx  = -1;
            monData = '0;
            if (expLoadIdx.size() != 0) begin
               monIdx  = expLoadIdx.pop_front();
               monData = expLoadData.pop_front();
            end
            checkOutput("load strobe", 64'(bus.load), (monIdx < 0) ? 64'd0 : (64'd1 << monIdx));
            checkOutput("data_out at load", bus.data_out, monData);
         end
      end
   end

   task automatic setAddr(input int i, input logic [ADDR_W-1:0] a);
      bus.req_addr[i*ADDR_W +: ADDR_W] = a;
   endtask

   task automatic expectAccess(input int i, input logic [ADDR_W-1:0] a, input bit withLoad);
      expAddrQ.push_back(a);
      if (withLoad) begin
         expLoadIdx.push_back(i);
         expLoadData.push_back(romWord(a));
      end
   endtask

   task automatic expectNull(input int i);
      expLoadIdx.push_back(i);
      expLoadData.push_back('0);
   endtask

   task automatic applyStimulus(input logic [NUM_REQ-1:0] toggleMask, input logic [NUM_REQ-1:0] nullMask);
      @(negedge clk);
      bus.req      = bus.req ^ toggleMask;
      bus.req_null = nullMask;
   endtask

   task automatic waitIdle(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(expAddrQ.size() == 0 && expLoadIdx.size() == 0 && !bus.busy && bus.req == bus.ack) && n < 300);
      checkOutput({name, " settles"}, 64'(n < 300), 64'd1);
   endtask

   task automatic doReset();
      @(negedge clk);
      reset        = 1'b1;
      bus.req      = '0;
      bus.req_null = '0;
      bus.flush    = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset ack", 64'(bus.ack), 64'd0);
      checkOutput("reset load", 64'(bus.load), 64'd0);
      checkOutput("reset data_out", bus.data_out, 64'd0);
      checkOutput("reset rom_req", 64'(bus.rom_req), 64'd0);
      checkOutput("reset rom_address", 64'(bus.rom_address), 64'd0);
      checkOutput("reset busy", 64'(bus.busy), 64'd0);
      reset = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      bus.req      = '0;
      bus.req_null = '0;
      bus.req_addr = '0;
      bus.flush    = 1'b0;
      doReset();

      // Single request
      setAddr(0, 23'h012340);
      expectAccess(0, 23'h012340, 1'b1);
      applyStimulus(4'b0001, 4'b0000);
      @(negedge clk);
      checkOutput("single rom_req", 64'(bus.rom_req), 64'd1);
      checkOutput("single busy", 64'(bus.busy), 64'd1);
      waitIdle("single");
      checkOutput("single ack", 64'(bus.ack), 64'h1);
      checkOutput("single busy after", 64'(bus.busy), 64'd0);
      checkOutput("single data_out", bus.data_out, 64'hDEADBEEF_01234567);

      // Round robin from reset priority
      doReset();
      for (int i = 0; i < NUM_REQ; i++) begin
         setAddr(i, ADDR_W'(23'h000100 * (i + 1)));
         expectAccess(i, ADDR_W'(23'h000100 * (i + 1)), 1'b1);
      end
      toggleCycles.delete();
      applyStimulus(4'b1111, 4'b0000);
      waitIdle("round robin");
      checkOutput("rr toggle count", 64'(toggleCycles.size()), 64'd4);
      for (int i = 1; i < 4 && i < toggleCycles.size(); i++)
         checkOutput("rr toggle spacing", 64'(toggleCycles[i] - toggleCycles[i-1]), 64'(ROM_LAT + 2));

      setAddr(0, 23'h000500);
      setAddr(2, 23'h000600);
      expectAccess(0, 23'h000500, 1'b1);
      expectAccess(2, 23'h000600, 1'b1);
      toggleCycles.delete();
      applyStimulus(4'b0101, 4'b0000);
      waitIdle("pair");
      checkOutput("pair toggle count", 64'(toggleCycles.size()), 64'd2);
      if (toggleCycles.size() == 2)
         checkOutput("pair toggle spacing", 64'(toggleCycles[1] - toggleCycles[0]), 64'(ROM_LAT + 2));

      // Null tile
      toggleCycles.delete();
      expectNull(1);
      applyStimulus(4'b0010, 4'b0010);
      @(negedge clk);
      checkOutput("null load", 64'(bus.load), 64'h2);
      checkOutput("null data_out", bus.data_out, 64'd0);
      checkOutput("null ack", 64'(bus.ack[1]), 64'(bus.req[1]));
      waitIdle("null");
      checkOutput("null no rom toggle", 64'(toggleCycles.size()), 64'd0);

      // Re-request while in flight: one more access with the newer address
      setAddr(2, 23'h002222);
      expectAccess(2, 23'h002222, 1'b1);
      expectAccess(2, 23'h003333, 1'b1);
      toggleCycles.delete();
      applyStimulus(4'b0100, 4'b0000);
      applyStimulus(4'b0100, 4'b0000);
      applyStimulus(4'b0100, 4'b0000);
      setAddr(2, 23'h003333);
      applyStimulus(4'b0100, 4'b0000);
      waitIdle("re-request");
      checkOutput("re-request toggle count", 64'(toggleCycles.size()), 64'd2);

      // Flush while busy
      dataBefore = bus.data_out;
      setAddr(0, 23'h004444);
      expectAccess(0, 23'h004444, 1'b0);
      toggleCycles.delete();
      applyStimulus(4'b0001, 4'b0000);
      applyStimulus(4'b1010, 4'b0000);
      @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      waitIdle("flush busy");
      checkOutput("flush ack", 64'(bus.ack), 64'(bus.req));
      checkOutput("flush data_out kept", bus.data_out, dataBefore);
      repeat (10) @(negedge clk);
      checkOutput("flush toggle count", 64'(toggleCycles.size()), 64'd1);

      // Flush in idle swallows a same-cycle request
      @(negedge clk);
      bus.req   = bus.req ^ 4'b1000;
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("idle flush ack", 64'(bus.ack), 64'(bus.req));
      checkOutput("idle flush toggles", 64'(toggleCycles.size()), 64'd1);

      // Reset mid-access
      setAddr(1, 23'h005555);
      expectAccess(1, 23'h005555, 1'b0);
      applyStimulus(4'b0010, 4'b0000);
      repeat (2) @(negedge clk);
      checkOutput("mid-access busy", 64'(bus.busy), 64'd1);
      reset   = 1'b1;
      bus.req = '0;
      @(negedge clk);
      checkOutput("mid reset rom_req", 64'(bus.rom_req), 64'd0);
      checkOutput("mid reset ack", 64'(bus.ack), 64'd0);
      checkOutput("mid reset busy", 64'(bus.busy), 64'd0);
      reset = 1'b0;

      setAddr(2, 23'h006666);
      expectAccess(2, 23'h006666, 1'b1);
      applyStimulus(4'b0100, 4'b0000);
      waitIdle("post reset");
      checkOutput("post reset data_out", bus.data_out, romWord(23'h006666));
      checkOutput("post reset ack", 64'(bus.ack), 64'h4);

      checkOutput("addr scoreboard drained", 64'(expAddrQ.size()), 64'd0);
      checkOutput("load scoreboard drained", 64'(expLoadIdx.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
